// File: rtl/axi_wr_req_arbiter.sv
// Round-robin arbiter sharing one AXI write controller among NUM_REQ requesters.
// One transaction outstanding at a time; grant and mux are held until the response returns.
//   state | meaning
//   IDLE  | no grant; searching req_valid from rr_ptr
//   GRANT | grant asserted, one-cycle wr_trn_en start pulse
//   BUSY  | grant/mux held, watchdog running, waiting for wr_rsp_en_d
//   DONE  | response pulsed to granted requester, rr_ptr advanced
module axi_wr_req_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int addr_width   = 32,
   parameter int data_width   = 64,
   parameter int strobe_width = data_width/8,
   parameter int TIMEOUT_CYC  = 1024,
   parameter int CMD_W        = addr_width+20
) (
   input  logic                            AClk,
   input  logic                            ARst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*CMD_W-1:0]        req_cmd,
   input  logic [NUM_REQ*data_width-1:0]   req_wdata,
   input  logic [NUM_REQ*strobe_width-1:0] req_wstrb,
   output logic [NUM_REQ-1:0]              req_grant,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [1:0]                      rsp_bresp,
   output logic [3:0]                      rsp_bid,
   output logic [addr_width-1:0]           awaddr_d,
   output logic [3:0]                      TXN_ID_W_d,
   output logic [1:0]                      awburst_d,
   output logic [3:0]                      awlen_d,
   output logic [2:0]                      awsize_d,
   output logic [1:0]                      awlock_d,
   output logic [1:0]                      awcache_d,
   output logic [2:0]                      awprot_d,
   output logic [data_width-1:0]           wdata_d,
   output logic [strobe_width-1:0]         wstrb_d,
   output logic                            wr_trn_en,
   input  logic [1:0]                      bresp_d,
   input  logic [3:0]                      bid_d,
   input  logic                            wr_rsp_en_d,
   output logic                            busy,
   output logic                            timeout_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYC+1);
   localparam logic [CNT_W-1:0] CNT_TC    = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_TC_M1 = CNT_W'(TIMEOUT_CYC-1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ-1);

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BUSY, ST_DONE} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   gnt_idx, gnt_idx_nxt, rr_ptr, sel_idx;
   logic               sel_found;
   logic [CNT_W-1:0]   wd_cnt;
   logic [NUM_REQ-1:0] gnt_onehot, gnt_onehot_nxt;
   logic [CMD_W-1:0]   cmd_sel;
   logic               grant_act;

   // Upward search from rr_ptr; iterating downward lets the nearest set bit win.
   always_comb begin
      int j;
      j         = 0;
      sel_idx   = rr_ptr;
      sel_found = 1'b0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         j = int'(rr_ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req_valid[IDX_W'(j)]) begin
            sel_idx   = IDX_W'(j);
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      gnt_idx_nxt = gnt_idx;
      case (state)
         ST_IDLE: begin
            if (sel_found) begin
               state_nxt   = ST_GRANT;
               gnt_idx_nxt = sel_idx;
            end
         end
         ST_GRANT: state_nxt = ST_BUSY;
         ST_BUSY:  if (wr_rsp_en_d) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge AClk) begin
      if (ARst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   assign gnt_onehot     = NUM_REQ'(1) << gnt_idx;
   assign gnt_onehot_nxt = NUM_REQ'(1) << gnt_idx_nxt;

   // Registered outputs are computed from the next state so they line up with it.
   always_ff @(posedge AClk) begin
      if (ARst) begin
         gnt_idx     <= '0;
         rr_ptr      <= '0;
         wd_cnt      <= '0;
         req_grant   <= '0;
         rsp_valid   <= '0;
         rsp_bresp   <= '0;
         rsp_bid     <= '0;
         wr_trn_en   <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         gnt_idx   <= gnt_idx_nxt;
         wr_trn_en <= (state_nxt == ST_GRANT);
         busy      <= (state_nxt != ST_IDLE);
         req_grant <= (state_nxt == ST_GRANT || state_nxt == ST_BUSY) ? gnt_onehot_nxt : '0;
         rsp_valid <= (state_nxt == ST_DONE) ? gnt_onehot : '0;
         if (state == ST_BUSY) begin
            if (wr_rsp_en_d) begin
               rsp_bresp <= bresp_d;
               rsp_bid   <= bid_d;
               wd_cnt    <= '0;
            end else if (wd_cnt != CNT_TC) begin
               wd_cnt <= wd_cnt + 1'b1;
               if (wd_cnt == CNT_TC_M1) timeout_err <= 1'b1;
            end
         end
         if (state == ST_DONE) rr_ptr <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
      end
   end

   assign grant_act = (state == ST_GRANT) || (state == ST_BUSY);

   always_comb begin
      cmd_sel = '0;
      wdata_d = '0;
      wstrb_d = '0;
      if (grant_act) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
               cmd_sel = req_cmd[i*CMD_W +: CMD_W];
               wdata_d = req_wdata[i*data_width +: data_width];
               wstrb_d = req_wstrb[i*strobe_width +: strobe_width];
            end
         end
      end
   end

   assign awaddr_d   = cmd_sel[addr_width-1:0];
   assign TXN_ID_W_d = cmd_sel[addr_width    +: 4];
   assign awburst_d  = cmd_sel[addr_width+4  +: 2];
   assign awlen_d    = cmd_sel[addr_width+6  +: 4];
   assign awsize_d   = cmd_sel[addr_width+10 +: 3];
   assign awlock_d   = cmd_sel[addr_width+13 +: 2];
   assign awcache_d  = cmd_sel[addr_width+15 +: 2];
   assign awprot_d   = cmd_sel[addr_width+17 +: 3];

endmodule

// File: tb/tb_axi_wr_req_arbiter.sv
// Scoreboard bench for axi_wr_req_arbiter: a round-robin order model feeds expected grants,
// a controller model feeds expected responses, and one monitor checks both.
module tb_axi_wr_req_arbiter;
   localparam int N = 4, AW = 32, DW = 64, SW = 8, TO = 1024, CW = AW + 20;

   logic AClk = 1'b0;
   logic ARst;
   logic [N-1:0]    req_valid;
   logic [N*CW-1:0] req_cmd;
   logic [N*DW-1:0] req_wdata;
   logic [N*SW-1:0] req_wstrb;
   logic [N-1:0]    req_grant, rsp_valid;
   logic [1:0]      rsp_bresp, awburst_d, awlock_d, awcache_d, bresp_d;
   logic [3:0]      rsp_bid, TXN_ID_W_d, awlen_d, bid_d;
   logic [AW-1:0]   awaddr_d;
   logic [2:0]      awsize_d, awprot_d;
   logic [DW-1:0]   wdata_d;
   logic [SW-1:0]   wstrb_d;
   logic            wr_trn_en, wr_rsp_en_d, busy, timeout_err;

   axi_wr_req_arbiter #(.NUM_REQ(N), .addr_width(AW), .data_width(DW), .strobe_width(SW),
                        .TIMEOUT_CYC(TO), .CMD_W(CW)) dut (
      .AClk(AClk), .ARst(ARst), .req_valid(req_valid), .req_cmd(req_cmd),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_grant(req_grant),
      .rsp_valid(rsp_valid), .rsp_bresp(rsp_bresp), .rsp_bid(rsp_bid),
      .awaddr_d(awaddr_d), .TXN_ID_W_d(TXN_ID_W_d), .awburst_d(awburst_d),
      .awlen_d(awlen_d), .awsize_d(awsize_d), .awlock_d(awlock_d),
      .awcache_d(awcache_d), .awprot_d(awprot_d), .wdata_d(wdata_d),
      .wstrb_d(wstrb_d), .wr_trn_en(wr_trn_en), .bresp_d(bresp_d), .bid_d(bid_d),
      .wr_rsp_en_d(wr_rsp_en_d), .busy(busy), .timeout_err(timeout_err));

   always #5 AClk = ~AClk;

   typedef struct {int idx; logic [CW-1:0] cmd; logic [DW-1:0] wd; logic [SW-1:0] ws;} gexp_t;
   typedef struct {int idx; logic [1:0] br; logic [3:0] bid; int cyc;} rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];
   int    ctl_q[$];

   logic [CW-1:0] cmd_m[N];
   logic [DW-1:0] wd_m[N];
   logic [SW-1:0] ws_m[N];

   int n_chk = 0, n_fail = 0, cyc = 0;
   int m_ptr = 0;
   int rsp_seen = 0, rsp_target = 0;
   bit hold_mode = 0, no_rsp = 0, abort = 0, fix_rsp = 0;
   logic [1:0] fix_br = '0;
   logic [3:0] fix_bid = '0;

   always @(posedge AClk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         req_cmd[i*CW +: CW]   = cmd_m[i];
         req_wdata[i*DW +: DW] = wd_m[i];
         req_wstrb[i*SW +: SW] = ws_m[i];
      end
   endtask

   task automatic randomize_reqs();
      for (int i = 0; i < N; i++) begin
         cmd_m[i] = CW'({$urandom, $urandom});
         wd_m[i]  = {$urandom, $urandom};
         ws_m[i]  = SW'($urandom);
      end
      drive_reqs();
   endtask

   // Round-robin reference: serve set bits of the pending mask in cyclic order from m_ptr.
   task automatic expect_grants(input logic [N-1:0] mask, input bit hold, input int ntxn);
      logic [N-1:0] pend;
      int idx;
      gexp_t g;
      pend = mask;
      for (int k = 0; k < ntxn; k++) begin
         idx = -1;
         for (int s = 0; s < N; s++)
            if (idx < 0 && pend[(m_ptr + s) % N]) idx = (m_ptr + s) % N;
         g.idx = idx; g.cmd = cmd_m[idx]; g.wd = wd_m[idx]; g.ws = ws_m[idx];
         gq.push_back(g);
         ctl_q.push_back(idx);
         m_ptr = (idx + 1) % N;
         if (!hold) pend[idx] = 1'b0;
      end
      hold_mode  = hold;
      rsp_seen   = 0;
      rsp_target = ntxn;
   endtask

   task automatic raise_and_check_latency(input logic [N-1:0] mask);
      @(negedge AClk);
      req_valid = mask;
      @(posedge AClk); #1;
      chk("grant_latency", 128'(wr_trn_en), 128'(1));
   endtask

   task automatic wait_rsps(input string name);
      int budget;
      budget = 0;
      while (rsp_seen < rsp_target && budget < 2000) begin
         @(negedge AClk);
         budget++;
      end
      if (rsp_seen < rsp_target) begin
         fail_now(name);
         req_valid = '0;
      end
      repeat (2) @(negedge AClk);
   endtask

   task automatic run_round(input logic [N-1:0] mask, input bit hold, input int ntxn);
      expect_grants(mask, hold, ntxn);
      raise_and_check_latency(mask);
      wait_rsps("round_timeout");
   endtask

   // Monitor: compares DUT presentations against the scoreboard queues.
   initial begin
      logic prev_trn;
      gexp_t g;
      rexp_t r;
      logic [N-1:0] oh;
      prev_trn = 1'b0;
      forever begin
         @(posedge AClk); #1;
         if (!ARst) begin
            if (wr_trn_en) begin
               chk("trn_single_pulse", 128'(prev_trn), 128'(0));
               if (gq.size() == 0) fail_now("unexpected_grant");
               else begin
                  g = gq.pop_front();
                  oh = '0; oh[g.idx] = 1'b1;
                  chk("grant_onehot", 128'(req_grant), 128'(oh));
                  chk("grant_cmd", 128'({awprot_d, awcache_d, awlock_d, awsize_d, awlen_d,
                                         awburst_d, TXN_ID_W_d, awaddr_d}), 128'(g.cmd));
                  chk("grant_wdata", 128'(wdata_d), 128'(g.wd));
                  chk("grant_wstrb", 128'(wstrb_d), 128'(g.ws));
                  chk("busy_on_grant", 128'(busy), 128'(1));
               end
            end
            if (rsp_valid != '0) begin
               if (rq.size() == 0) fail_now("unexpected_rsp_valid");
               else begin
                  r = rq.pop_front();
                  oh = '0; oh[r.idx] = 1'b1;
                  chk("rsp_onehot", 128'(rsp_valid), 128'(oh));
                  chk("rsp_bresp", 128'(rsp_bresp), 128'(r.br));
                  chk("rsp_bid", 128'(rsp_bid), 128'(r.bid));
                  chk("rsp_latency", 128'(cyc), 128'(r.cyc));
                  chk("grant_off_in_done", 128'(req_grant), 128'(0));
                  chk("busy_in_done", 128'(busy), 128'(1));
               end
            end
            if (req_grant == '0)
               chk("idle_mux_zero", 128'({awprot_d, awcache_d, awlock_d, awsize_d, awlen_d,
                                          awburst_d, TXN_ID_W_d, awaddr_d, wdata_d, wstrb_d,
                                          wr_trn_en}), 128'(0));
         end
         prev_trn = wr_trn_en;
      end
   end

   // Controller model: answers each start pulse after a random BUSY delay.
   initial begin
      wr_rsp_en_d = 1'b0; bresp_d = '0; bid_d = '0;
      forever begin
         @(posedge AClk); #1;
         if (wr_trn_en && !ARst) begin
            int idx, d;
            bit skip;
            rexp_t r;
            idx = (ctl_q.size() > 0) ? ctl_q.pop_front() : 0;
            @(negedge AClk);
            @(posedge AClk);
            skip = 1'b0;
            while (no_rsp && !skip) begin
               if (abort) skip = 1'b1;
               else @(posedge AClk);
            end
            if (!skip) begin
               d = $urandom_range(0, 4);
               repeat (d) @(posedge AClk);
               @(negedge AClk);
               r.idx = idx;
               r.br  = fix_rsp ? fix_br  : 2'($urandom);
               r.bid = fix_rsp ? fix_bid : 4'($urandom);
               r.cyc = cyc + 1;
               rq.push_back(r);
               bresp_d = r.br; bid_d = r.bid; wr_rsp_en_d = 1'b1;
               @(negedge AClk);
               wr_rsp_en_d = 1'b0; bresp_d = 2'($urandom); bid_d = 4'($urandom);
            end
         end
      end
   end

   // Requester behaviour: drop request after its response, or hold until the round ends.
   initial begin
      forever begin
         @(negedge AClk);
         if (rsp_valid != '0) begin
            rsp_seen++;
            if (!hold_mode) req_valid = req_valid & ~rsp_valid;
            else if (rsp_seen >= rsp_target) req_valid = '0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] mask;
      bit hold;
      int ntxn;
      ARst = 1'b1; req_valid = '0;
      randomize_reqs();
      repeat (3) @(posedge AClk);
      #1;
      chk("reset_outputs", 128'({req_grant, rsp_valid, rsp_bresp, rsp_bid, wr_trn_en, busy,
                                 timeout_err, awaddr_d, wdata_d, wstrb_d}), 128'(0));
      @(negedge AClk); ARst = 1'b0;
      repeat (2) @(negedge AClk);

      // Single request on 2: addr 0x1000, len 3, response bresp 0 / bid 5.
      randomize_reqs();
      cmd_m[2] = {3'd0, 2'd0, 2'd0, 3'd3, 4'd3, 2'd1, 4'd0, 32'h0000_1000};
      drive_reqs();
      fix_rsp = 1'b1; fix_br = 2'd0; fix_bid = 4'd5;
      run_round(4'b0100, 1'b0, 1);
      fix_rsp = 1'b0;

      // Pointer now 3: requests on 1 and 3 serve 3 first, then 1.
      randomize_reqs();
      run_round(4'b1010, 1'b0, 2);

      // Watchdog: no response for TIMEOUT_CYC cycles, then a late response.
      randomize_reqs();
      expect_grants(4'b0001, 1'b0, 1);
      no_rsp = 1'b1;
      raise_and_check_latency(4'b0001);
      repeat (1000) @(posedge AClk);
      #1;
      chk("timeout_not_yet", 128'(timeout_err), 128'(0));
      repeat (30) @(posedge AClk);
      #1;
      chk("timeout_set", 128'(timeout_err), 128'(1));
      chk("grant_held_timeout", 128'(req_grant), 128'(4'b0001));
      @(negedge AClk); no_rsp = 1'b0;
      wait_rsps("late_rsp_timeout");
      chk("timeout_sticky", 128'(timeout_err), 128'(1));

      // Reset during BUSY aborts the transaction with no response pulse.
      randomize_reqs();
      expect_grants(4'b0100, 1'b0, 1);
      no_rsp = 1'b1;
      raise_and_check_latency(4'b0100);
      repeat (5) @(posedge AClk);
      @(negedge AClk); ARst = 1'b1; req_valid = '0; abort = 1'b1;
      @(posedge AClk); #1;
      chk("reset_mid_txn", 128'({req_grant, rsp_valid, rsp_bresp, rsp_bid, wr_trn_en, busy,
                                 timeout_err, awaddr_d, wdata_d, wstrb_d}), 128'(0));
      @(negedge AClk); ARst = 1'b0; m_ptr = 0;
      repeat (4) @(negedge AClk);
      no_rsp = 1'b0; abort = 1'b0;
      repeat (4) @(negedge AClk);

      // All four held high for 8 transactions: 0,1,2,3,0,1,2,3.
      randomize_reqs();
      run_round(4'b1111, 1'b1, 8);

      // Response strobe while idle, with mux inputs toggling: no effect.
      repeat (12) begin
         @(negedge AClk);
         randomize_reqs();
         wr_rsp_en_d = 1'($urandom); bresp_d = 2'($urandom); bid_d = 4'($urandom);
      end
      @(negedge AClk); wr_rsp_en_d = 1'b0;
      @(posedge AClk); #1;
      chk("idle_rsp_ignored", 128'({busy, rsp_valid, req_grant}), 128'(0));

      // Random rounds.
      for (int k = 0; k < 12; k++) begin
         randomize_reqs();
         mask = N'($urandom_range(1, (1 << N) - 1));
         hold = 1'($urandom);
         ntxn = hold ? $urandom_range(1, 6) : $countones(mask);
         run_round(mask, hold, ntxn);
      end

      repeat (5) @(negedge AClk);
      if (gq.size() != 0 || rq.size() != 0) fail_now("scoreboard_leftover");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
